// File: rtl/mul_controller.sv
// ---------------------------------------------------------------------------
// mul_controller
//   Control FSM for the 4x4 multiplier datapath built from four 2x2 partial
//   products. Sequences hh, hl, lh, ll into the 8-bit accumulator as
//   ((hh<<2) + hl + lh)<<2 + ll, and provides a start/busy/done handshake.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active low
//   start    in   multiply request, level, only looked at in IDLE
//   busy     out  high in LOAD..LL
//   done     out  product valid on the datapath output
//   clr_acc  out  one-cycle accumulator clear (same cycle as ld_1)
//   ld_1     out  load operand registers a, b
//   ld_2     out  load accumulator
//   s0       out  a nibble select: 0 = a[1:0], 1 = a[3:2]
//   s1       out  b nibble select: 0 = b[1:0], 1 = b[3:2]
//   s2       out  accumulator feedback: 0 = acc<<2, 1 = acc
//
// Parameter
//   HOLD_DONE  0: done is a one-cycle pulse
//              1: done holds until start is sampled low
//
// Timing: start seen high in IDLE during cycle N -> LOAD in N+1, HH..LL in
// N+2..N+5, done in cycle N+6. All outputs are decoded from the state
// register only, so there is no path from start to any output.
// ---------------------------------------------------------------------------
module mul_controller #(
    parameter int HOLD_DONE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic clr_acc,
    output logic ld_1,
    output logic ld_2,
    output logic s0,
    output logic s1,
    output logic s2
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HH   = 3'd2,
        S_HL   = 3'd3,
        S_LH   = 3'd4,
        S_LL   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic; encoding 3'd7 falls to the default and recovers to IDLE
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: w_next = start ? S_LOAD : S_IDLE;
            S_LOAD: w_next = S_HH;
            S_HH:   w_next = S_HL;
            S_HL:   w_next = S_LH;
            S_LH:   w_next = S_LL;
            S_LL:   w_next = S_DONE;
            S_DONE: begin
                if (HOLD_DONE != 0 && start) w_next = S_DONE;
                else                         w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        clr_acc = 1'b0;
        ld_1    = 1'b0;
        ld_2    = 1'b0;
        s0      = 1'b0;
        s1      = 1'b0;
        s2      = 1'b0;
        case (r_state)
            S_LOAD: begin
                busy    = 1'b1;
                ld_1    = 1'b1;
                clr_acc = 1'b1;
            end
            // acc was just cleared, so the unshifted feedback gives hh + 0
            S_HH: begin
                busy = 1'b1; ld_2 = 1'b1; s0 = 1'b1; s1 = 1'b1; s2 = 1'b1;
            end
            S_HL: begin
                busy = 1'b1; ld_2 = 1'b1; s0 = 1'b1;
            end
            S_LH: begin
                busy = 1'b1; ld_2 = 1'b1; s1 = 1'b1; s2 = 1'b1;
            end
            S_LL: begin
                busy = 1'b1; ld_2 = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mul_controller.sv
module tb_mul_controller;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1;
    logic busy0, done0, clr0, ld1_0, ld2_0, s0_0, s1_0, s2_0;
    logic busy1, done1, clr1, ld1_1, ld2_1, s0_1, s1_1, s2_1;

    always #5 clk = ~clk;

    mul_controller #(.HOLD_DONE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .busy(busy0), .done(done0), .clr_acc(clr0), .ld_1(ld1_0), .ld_2(ld2_0),
        .s0(s0_0), .s1(s1_0), .s2(s2_0)
    );

    mul_controller #(.HOLD_DONE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .busy(busy1), .done(done1), .clr_acc(clr1), .ld_1(ld1_1), .ld_2(ld2_1),
        .s0(s0_1), .s1(s1_1), .s2(s2_1)
    );

    // Reference 2x2-partial-product datapath driven by u_dut0's control pins
    logic [3:0] a_in, b_in, a_r, b_r;
    logic [7:0] acc;
    logic [1:0] w_asel, w_bsel;
    assign w_asel = s0_0 ? a_r[3:2] : a_r[1:0];
    assign w_bsel = s1_0 ? b_r[3:2] : b_r[1:0];

    always @(posedge clk) begin
        if (ld1_0) begin
            a_r <= a_in;
            b_r <= b_in;
        end
        if (clr0)      acc <= 8'h00;
        else if (ld2_0) acc <= (s2_0 ? acc : {acc[5:0], 2'b00}) + 8'(w_asel * w_bsel);
    end

    // Control vector {busy, done, clr_acc, ld_1, ld_2, s0, s1, s2}
    localparam logic [7:0] C_IDLE = 8'h00;
    localparam logic [7:0] C_LOAD = 8'hB0;
    localparam logic [7:0] C_HH   = 8'h8F;
    localparam logic [7:0] C_HL   = 8'h8C;
    localparam logic [7:0] C_LH   = 8'h8B;
    localparam logic [7:0] C_LL   = 8'h88;
    localparam logic [7:0] C_DONE = 8'h40;

    logic [7:0] ctrl0, ctrl1;
    assign ctrl0 = {busy0, done0, clr0, ld1_0, ld2_0, s0_0, s1_0, s2_0};
    assign ctrl1 = {busy1, done1, clr1, ld1_1, ld2_1, s0_1, s1_1, s2_1};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation on u_dut0 from IDLE. hold keeps start high through
    // the whole sequence; glitch toggles start during HH..LL.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] prod, input bit hold, input bit glitch);
        logic [7:0] exp_seq [0:4];
        exp_seq[0] = C_HH; exp_seq[1] = C_HL; exp_seq[2] = C_LH;
        exp_seq[3] = C_LL; exp_seq[4] = C_DONE;
        a_in = a; b_in = b; start0 = 1'b1;
        tick();
        chk({tag, "_load"}, ctrl0, C_LOAD);
        if (!hold) start0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("%s_seq%0d", tag, i), ctrl0, exp_seq[i]);
            if (glitch && i < 4) start0 = ~start0;
        end
        chk({tag, "_out"}, acc, prod);
        if (glitch) start0 = 1'b1;  // start high in DONE must not matter
        tick();
        chk({tag, "_idle"}, ctrl0, C_IDLE);
        chk({tag, "_hold"}, acc, prod);
        if (glitch) start0 = 1'b0;
    endtask

    initial begin
        int  dcount;
        bit  held;
        rst = 1'b0; start0 = 1'b1; start1 = 1'b1;
        a_in = 4'hF; b_in = 4'hF;

        // Reset held 3 cycles with start high
        for (int i = 0; i < 3; i++) tick();
        chk("rst_ctrl0", ctrl0, C_IDLE);
        chk("rst_ctrl1", ctrl1, C_IDLE);

        // Release: first edge sampling start=1 goes to LOAD; runs F*F
        rst = 1'b1; start1 = 1'b0;
        tick();
        chk("rel_load", ctrl0, C_LOAD);
        start0 = 1'b0;
        begin
            logic [7:0] seq [0:4];
            seq[0] = C_HH; seq[1] = C_HL; seq[2] = C_LH; seq[3] = C_LL; seq[4] = C_DONE;
            for (int i = 0; i < 5; i++) begin
                tick();
                chk($sformatf("ff_seq%0d", i), ctrl0, seq[i]);
            end
        end
        chk("ff_out", acc, 8'hE1);
        tick();
        chk("ff_pulse", ctrl0, C_IDLE);
        chk("idle1", ctrl1, C_IDLE);

        // Back-to-back with start held high: stale accumulator would show up
        run_op("m9x6",  4'd9, 4'd6,  8'h36, 1'b1, 1'b0);
        run_op("m0x13", 4'd0, 4'd13, 8'h00, 1'b1, 1'b0);
        run_op("m1x1",  4'd1, 4'd1,  8'h01, 1'b0, 1'b0);

        // Reset in LH
        a_in = 4'd3; b_in = 4'd5; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("mid_lh", ctrl0, C_LH);
        rst = 1'b0;
        tick();
        chk("mid_rst", ctrl0, C_IDLE);
        rst = 1'b1;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done0) dcount++;
        end
        chk("mid_nodone", 8'(dcount), 8'd0);
        run_op("m7x11", 4'd7, 4'd11, 8'h4D, 1'b0, 1'b0);

        // start toggling while busy, and high in DONE
        run_op("glitch", 4'd12, 4'd10, 8'h78, 1'b0, 1'b1);

        // HOLD_DONE=1: start held high for 20 cycles
        start1 = 1'b1;
        tick();
        chk("h1_load", ctrl1, C_LOAD);
        for (int i = 0; i < 5; i++) tick();
        chk("h1_done", ctrl1, C_DONE);
        held = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (ctrl1 !== C_DONE) held = 1'b0;
        end
        chk("h1_held", 8'(held), 8'd1);
        start1 = 1'b0;
        tick();
        chk("h1_idle", ctrl1, C_IDLE);
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ctrl1 !== C_IDLE) dcount++;
        end
        chk("h1_noretrig", 8'(dcount), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
